// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer that drives one external MAC (a/b/sclr/load) and returns the result.
// Optional MAC_SEQ_OVF_EN keeps a full-width shadow sum so out_ovf can flag modulo wrap-around.
module mac_seq #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4
) (
    input  logic             sys_clock,
    input  logic             sys_reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mac_a,
    output logic [WIDTH-1:0] mac_b,
    output logic             mac_sclr,
    output logic             mac_load,
    input  logic [WIDTH-1:0] mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int            CW   = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          in_fire;

    assign in_fire = in_valid && in_ready;

    // NOTE: every register here uses non-blocking assignment so all state updates at one edge see the
    // pre-edge values, which is what keeps mac_a/mac_b/mac_load exactly one cycle behind the handshake.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_sclr  <= 1'b0;
            mac_load  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        mac_sclr <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    state    <= FEED;
                    mac_sclr <= 1'b0;
                    in_ready <= 1'b1;
                end
                FEED: begin
                    // Bubbles drop mac_load so the MAC holds; mac_a/mac_b keep the last pair.
                    mac_load <= in_fire;
                    if (in_fire) begin
                        mac_a <= in_a;
                        mac_b <= in_b;
                        if (count == LAST) begin
                            count    <= '0;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    mac_load <= 1'b0;
                    state    <= CAPT;
                end
                CAPT: begin
                    out_data  <= mac_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    in_ready  <= 1'b0;
                    mac_sclr  <= 1'b0;
                    mac_load  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAC_SEQ_OVF_EN
    localparam int SW = 2*WIDTH + $clog2(LEN);

    logic [SW-1:0] shadow;

    // Shadow sum tracks the untruncated dot product; any bit above WIDTH means the MAC wrapped.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            shadow  <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                CLEAR:   shadow <= '0;
                FEED:    if (in_fire) shadow <= shadow + SW'(in_a) * SW'(in_b);
                CAPT:    out_ovf <= |shadow[SW-1:WIDTH];
                DONE:    if (out_ready) out_ovf <= 1'b0;
                default: ;
            endcase
        end
    end
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives mac_seq with directed and random dot products against an in-bench MAC and sum model.
// Build with MAC_SEQ_OVF_EN defined to also expect the overflow flag.
module tb_mac_seq;

    localparam int W = 4;
    localparam int L = 4;

    logic         sys_clock = 1'b0;
    logic         sys_reset = 1'b0;
    logic         start, in_valid, in_ready, out_ready, out_valid, out_ovf, busy;
    logic         mac_sclr, mac_load;
    logic [W-1:0] in_a, in_b, mac_a, mac_b, mac_result, out_data;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clock = ~sys_clock;

    mac_seq #(.WIDTH(W), .LEN(L)) dut (
        .sys_clock (sys_clock),
        .sys_reset (sys_reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_sclr  (mac_sclr),
        .mac_load  (mac_load),
        .mac_result(mac_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // External MAC: not touched by sys_reset, so a partial sum survives until the next sclr.
    logic [W-1:0] mac_acc = '0;
    always @(posedge sys_clock) begin
        if (mac_sclr)      mac_acc <= '0;
        else if (mac_load) mac_acc <= mac_acc + mac_a * mac_b;
    end
    assign mac_result = mac_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    function automatic logic [31:0] all_outputs();
        return {14'd0, in_ready, mac_a, mac_b, mac_sclr, mac_load, out_valid, out_data, out_ovf, busy};
    endfunction

    // Reference model: every accepted pair adds its full product; the L-th pair closes a dot product.
    logic         hs_last = 1'b0;
    logic [W-1:0] last_a = '0, last_b = '0;
    logic [W-1:0] exp_data;
    logic         exp_ovf = 1'b0;
    int           run_sum = 0, run_cnt = 0, prod, total;

    always @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            hs_last <= 1'b0;
            last_a  <= '0;
            last_b  <= '0;
            run_sum <= 0;
            run_cnt <= 0;
        end else begin
            hs_last <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                prod   = int'(in_a) * int'(in_b);
                total  = run_sum + prod;
                last_a <= in_a;
                last_b <= in_b;
                if (run_cnt == L - 1) begin
                    exp_data <= W'(total % (1 << W));
`ifdef MAC_SEQ_OVF_EN
                    exp_ovf  <= (total >= (1 << W));
`else
                    exp_ovf  <= 1'b0;
`endif
                    run_sum  <= 0;
                    run_cnt  <= 0;
                end else begin
                    run_sum <= total;
                    run_cnt <= run_cnt + 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    int load_cycles = 0;
    always @(negedge sys_clock) begin
        if (!sys_reset) begin
            check("mac_load_follows_handshake", mac_load, hs_last);
            check("mac_ab_last_pair", {mac_a, mac_b}, {last_a, last_b});
            if (!busy) check("idle_outputs_quiet", {in_ready, out_valid, mac_sclr, mac_load}, 0);
            if (out_valid) begin
                check("out_data", out_data, exp_data);
                check("out_ovf", out_ovf, exp_ovf);
                check("no_ready_while_done", {in_ready, busy}, 2'b01);
            end
            if (mac_load) load_cycles++;
        end
    end

    logic [W-1:0] pa[L], pb[L];

    // One full dot product from pa/pb. gap<0 means random 0..2 bubbles between pairs.
    task automatic run_dot(input int gap, input int ready_delay, input bit noisy,
                           output logic [W-1:0] res, output logic ovf);
        int ref_sum = 0;
        int loads0  = load_cycles;
        int k;
        int g;
        for (int i = 0; i < L; i++) ref_sum += int'(pa[i]) * int'(pb[i]);
        start = 1'b1;
        tick();
        start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        check("sclr_after_start", mac_sclr, 1);
        check("no_ready_in_clear", in_ready, 0);
        check("busy_after_start", busy, 1);
        tick();
        check("sclr_single_cycle", mac_sclr, 0);
        check("ready_in_feed", in_ready, 1);
        for (int i = 0; i < L; i++) begin
            in_valid = 1'b1;
            in_a     = pa[i];
            in_b     = pb[i];
            tick();
            in_valid = 1'b0;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            if (i < L - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                for (int j = 0; j < g; j++) begin
                    if (noisy) start = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        check("no_ready_after_last_pair", in_ready, 0);
        if (noisy) in_valid = 1'($urandom_range(0, 1));
        // DONE is entered on the third edge counting the last-handshake edge itself.
        k = 0;
        while (k < 8 && !out_valid) begin
            tick();
            k++;
        end
        check("result_latency_edges", k, 2);
        res = out_data;
        ovf = out_ovf;
        check("result_vs_ref", out_data, ref_sum % (1 << W));
        check("mac_load_pulses", load_cycles - loads0, L);
        out_ready = 1'b0;
        for (int j = 0; j < ready_delay; j++) begin
            if (noisy) start = ~start;
            tick();
            check("valid_held_in_stall", out_valid, 1);
        end
        out_ready = 1'b1;
        start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        check("released_to_idle", {out_valid, busy}, 0);
        tick();
        check("no_restart_after_done", {busy, mac_sclr}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        logic [W-1:0] r;
        logic         o;
        start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #1 sys_reset = 1'b1;
        #2 check("reset_outputs", all_outputs(), 0);
        tick();
        in_valid = 1'b1;
        tick();
        sys_reset = 1'b0;
        tick();
        tick();
        check("idle_ignores_in_valid", {in_ready, busy, mac_load}, 0);
        in_valid = 1'b0;

        pa = '{4'd1, 4'd2, 4'd3, 4'd4};
        pb = '{4'd1, 4'd1, 4'd1, 4'd1};
        run_dot(0, 0, 1'b0, r, o);
        check("T1_sum", r, 10);
        check("T1_ovf", o, 0);

        pa = '{4'd15, 4'd15, 4'd15, 4'd15};
        pb = '{4'd15, 4'd15, 4'd15, 4'd15};
        run_dot(0, 1, 1'b0, r, o);
        check("T2_sum", r, 4);
`ifdef MAC_SEQ_OVF_EN
        check("T2_ovf", o, 1);
`else
        check("T2_ovf", o, 0);
`endif

        pa = '{4'd2, 4'd1, 4'd2, 4'd0};
        pb = '{4'd3, 4'd1, 4'd2, 4'd5};
        run_dot(2, 0, 1'b0, r, o);
        check("T3_sum", r, 11);

        pa = '{4'd1, 4'd2, 4'd3, 4'd4};
        pb = '{4'd1, 4'd1, 4'd1, 4'd1};
        run_dot(0, 5, 1'b1, r, o);
        check("T4_sum", r, 10);

        // Abort after two accepted pairs; the MAC keeps its partial sum until the next clear.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
        tick();
        tick();
        in_valid = 1'b0;
        #2 sys_reset = 1'b1;
        #1 check("T5_reset_mid_run", all_outputs(), 0);
        tick();
        sys_reset = 1'b0;
        tick();
        pa = '{4'd1, 4'd1, 4'd1, 4'd1};
        pb = '{4'd2, 4'd2, 4'd2, 4'd2};
        run_dot(-1, 0, 1'b0, r, o);
        check("T5_sum", r, 8);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < L; i++) begin
                pa[i] = W'($urandom);
                pb[i] = W'($urandom);
            end
            run_dot(-1, int'($urandom_range(0, 3)), 1'b1, r, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
